seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring divider for the processor's multiply/divide unit.
- Divides a 32-bit dividend by a 32-bit divisor, one quotient bit per clock, with one trial subtraction per bit.
- Produces a quotient, a remainder and a divide-by-zero exception through a start/ready handshake.
- Sits beside the ALU and is launched by the DIV control decode.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  single-cycle request; operands are sampled on the same edge.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_zero  output  1  exception flag; divisor was zero.
- busy  output  1  high while an operation is in flight.
- result_rdy  output  1  one-cycle pulse; results are valid.

Behaviour:
- Single clock domain. `reset` is asynchronous and active-high.
- Reset values: quotient=0, remainder=0, div_zero=0, busy=0, result_rdy=0, state=IDLE, counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, start=1, divisor!=0:
  - Latch operand magnitudes and signs. Zero the partial remainder.
  - counter=0, go to RUN, busy=1.
- IDLE or DONE, start=1, divisor==0:
  - Go to DONE.
  - quotient=0, remainder=dividend, div_zero=1, result_rdy=1 on that same edge.
- RUN, each edge:
  - Shift {rem,quo} left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude from rem.
  - If non-negative: keep the difference, quotient bit=1. Otherwise: restore rem, bit=0.
  - counter++. When counter==WIDTH-1, go to FIX.
- FIX, one edge:
  - Apply signs. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign (truncation toward zero).
  - Register the outputs, div_zero=0, result_rdy=1, busy=0, go to DONE.
- DONE:
  - result_rdy returns to 0 after one cycle.
  - Outputs hold until the next accepted start.
  - DONE behaves as IDLE for start.
- Latency: result_rdy rises on the (WIDTH+1)th rising edge after the start-sampling edge (33 for WIDTH=32). It is constant and independent of operand values.
- start while busy=1 (RUN/FIX) is ignored. Latched operands are unaffected.
- start in the same cycle result_rdy=1 is accepted. The current results are still presented for that cycle.
- Overflow case -2^(WIDTH-1) / -1: quotient wraps to 0x80000000, remainder=0, no exception.
- Magnitude of -2^(WIDTH-1) is computed in WIDTH+1 bits, so it is not truncated.
- reset mid-operation: immediate return to the reset values. No result_rdy pulse is produced.

Optional Feature:
- Macro `SEQ_DIVIDER_SIGNED_EN`.
- Defined: two's-complement signed division as above.
- Undefined: operands are treated as unsigned.
  - No magnitude/sign conversion is done.
  - The FIX state still exists as a pass-through register cycle, so latency is identical.

Decomposition:
- Shared package `div_pkg`:
  - state enum (IDLE, RUN, FIX, DONE).
  - DIV_WIDTH default 32.
  - function abs_val.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, next dividend bit, divisor magnitude.
  - Outputs: new rem, quotient bit.
  - Trial subtraction is done with the team's 32-bit carry-lookahead adder in subtract mode (B inverted, c0=1) when WIDTH=32.
- The FSM, counter and sign logic stay in `seq_divider`.

Test Plan:
- 100 / 7:
  - busy high for edges 1-32.
  - result_rdy pulse after edge 33 with quotient=14, remainder=2, div_zero=0.
- Signed -100 / 7 (macro defined): quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- Same operands unsigned (macro undefined): quotient=0x24924916, remainder=2.
- 5 / 0: result_rdy after edge 1, div_zero=1, quotient=0, remainder=5. A following 9/3 gives div_zero=0, quotient=3, remainder=0.
- 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0, div_zero=0.
- Mid-run events:
  - Second start with 50/5 at edge 5 is ignored; the result is still 14 r 2.
  - reset asserted at edge 10 clears all outputs and busy asynchronously, with no result_rdy.
  - Back-to-back: start 20/6 on the result_rdy cycle yields 3 r 2 after 33 more edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider slice.
package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement value, returned as an unsigned number.
  // The most negative input -2^(DIV_WIDTH-1) negates to the bit pattern
  // 1000...0, which read as unsigned is exactly 2^(DIV_WIDTH-1), so the
  // magnitude is never truncated.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] value);
    return value[DIV_WIDTH-1] ? -value : value;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups with a rippled
// group carry. Subtraction is done by the caller: invert B and set c0_i.
module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c0_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int GROUPS = (WIDTH + 3) / 4;
  localparam int PW     = GROUPS * 4;

  logic [PW-1:0] gen;
  logic [PW-1:0] prop;
  logic [PW:0]   carry;

  // Per-bit generate/propagate, zero-padded to a whole number of groups.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    gen              = '0;
    prop             = '0;
    gen[WIDTH-1:0]   = a_i & b_i;
    prop[WIDTH-1:0]  = a_i ^ b_i;
  end

  // Lookahead carries inside each group; group carry-out feeds the next group.
  always_comb begin
    carry    = '0;
    carry[0] = c0_i;
    for (int grp = 0; grp < GROUPS; grp++) begin
      carry[4*grp+1] = gen[4*grp]
                     | (prop[4*grp] & carry[4*grp]);
      carry[4*grp+2] = gen[4*grp+1]
                     | (prop[4*grp+1] & gen[4*grp])
                     | (prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
      carry[4*grp+3] = gen[4*grp+2]
                     | (prop[4*grp+2] & gen[4*grp+1])
                     | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                     | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
      carry[4*grp+4] = gen[4*grp+3]
                     | (prop[4*grp+3] & gen[4*grp+2])
                     | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                     | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                     | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & prop[4*grp]
                        & carry[4*grp]);
    end
  end

  assign sum_o  = prop[WIDTH-1:0] ^ carry[WIDTH-1:0];
  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep the difference or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             shift_msb;

  // The shifted remainder is WIDTH+1 bits wide. Its top bit is kept apart:
  // when it is set the value already exceeds any divisor, the subtraction
  // must succeed, and the WIDTH-bit difference is exact.
  assign shift_msb = rem_i[WIDTH-1];
  assign shifted   = {rem_i[WIDTH-2:0], dvd_bit_i};

  cla_adder #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .a_i    (shifted),
    .b_i    (~dvs_mag_i),
    .c0_i   (1'b1),
    .sum_o  (diff),
    .cout_o (no_borrow)
  );

  // Keep the difference when it is non-negative, otherwise restore.
  always_comb begin
    q_bit_o = shift_msb | no_borrow;
    rem_o   = q_bit_o ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/ready
// handshake, divide-by-zero flag, constant WIDTH+1 cycle latency.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement signed
// division (quotient truncates toward zero, remainder takes the dividend's
// sign); undefined, operands are unsigned and FIX is a pass-through cycle.
// The signed magnitude helper is sized by DIV_WIDTH, so keep WIDTH equal to it
// in signed builds.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             result_rdy
);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;         // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d;                 // operand signs differ
  logic r_neg_q, r_neg_d;                 // dividend was negative

  assign dvd_mag = abs_val(dividend);
  assign dvs_mag = abs_val(divisor);
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .dvs_mag_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // Next-state and datapath updates for each control state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    busy_d      = busy_q;
    rdy_d       = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            rdy_d       = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvs_d   = dvs_mag;
            busy_d  = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
`endif
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d  = quo_fix;
        remainder_d = rem_fix;
        div_zero_d  = 1'b0;
        rdy_d       = 1'b1;
        busy_d      = 1'b0;
        state_d     = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  assign quotient   = quotient_q;
  assign remainder  = remainder_q;
  assign div_zero   = div_zero_q;
  assign busy       = busy_q;
  assign result_rdy = rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, latency/handshake, sign handling,
// divide-by-zero, ignored start, mid-run reset and back-to-back launch.
module tb_seq_divider;

  localparam int W = 32;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [W-1:0] NEG_Q = 32'hFFFF_FFF2;
  localparam logic [W-1:0] NEG_R = 32'hFFFF_FFFE;
  localparam logic [W-1:0] OVF_Q = 32'h8000_0000;
  localparam logic [W-1:0] OVF_R = 32'h0000_0000;
`else
  localparam logic [W-1:0] NEG_Q = 32'h2492_4916;
  localparam logic [W-1:0] NEG_R = 32'h0000_0002;
  localparam logic [W-1:0] OVF_Q = 32'h0000_0000;
  localparam logic [W-1:0] OVF_R = 32'h8000_0000;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         busy;
  logic         result_rdy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  seq_divider dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .busy       (busy),
    .result_rdy (result_rdy)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a one-cycle start; afterwards the operand inputs are scrambled so
  // any result depending on unlatched inputs shows up.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
  endtask

  // Count edges until result_rdy is seen, bounded at 40.
  task automatic wait_rdy(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!result_rdy && edges < 40);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    vectors++;
    if ({quotient, remainder, div_zero, busy, result_rdy} !== {(2*W+3){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_async: q=%h r=%h dz=%b busy=%b rdy=%b, want all zero",
               quotient, remainder, div_zero, busy, result_rdy);
    end
    step();
    step();
    #2 reset = 1'b0;
    step();
    vectors++;
    if ({quotient, remainder, div_zero, busy, result_rdy} !== {(2*W+3){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_release: q=%h r=%h dz=%b busy=%b rdy=%b, want all zero",
               quotient, remainder, div_zero, busy, result_rdy);
    end
  endtask

  task automatic test_basic();
    logic exp_busy;
    logic exp_rdy;
    launch(32'd100, 32'd7);
    for (int e = 1; e <= 33; e++) begin
      step();
      exp_busy = (e <= 32);
      exp_rdy  = (e == 33);
      vectors++;
      if ({busy, result_rdy} !== {exp_busy, exp_rdy}) begin
        miscompares++;
        $display("FAIL basic_handshake edge %0d: busy=%b rdy=%b, want busy=%b rdy=%b",
                 e, busy, result_rdy, exp_busy, exp_rdy);
      end
    end
    vectors++;
    if ({quotient, remainder, div_zero} !== {32'd14, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_100_7: q=%0d r=%0d dz=%b, want q=14 r=2 dz=0",
               quotient, remainder, div_zero);
    end
    step();
    vectors++;
    if ({result_rdy, quotient, remainder} !== {1'b0, 32'd14, 32'd2}) begin
      miscompares++;
      $display("FAIL basic_hold: rdy=%b q=%0d r=%0d, want rdy=0 q=14 r=2",
               result_rdy, quotient, remainder);
    end
  endtask

  task automatic test_sign_handling();
    int edges;
    launch(32'hFFFF_FF9C, 32'd7);   // -100 / 7
    wait_rdy(edges);
    vectors++;
    if (edges !== 33) begin
      miscompares++;
      $display("FAIL neg_latency: %0d edges, want 33", edges);
    end
    vectors++;
    if ({quotient, remainder, div_zero} !== {NEG_Q, NEG_R, 1'b0}) begin
      miscompares++;
      $display("FAIL neg_100_7: q=%h r=%h dz=%b, want q=%h r=%h dz=0",
               quotient, remainder, div_zero, NEG_Q, NEG_R);
    end
  endtask

  task automatic test_overflow();
    int edges;
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(edges);
    vectors++;
    if (edges !== 33) begin
      miscompares++;
      $display("FAIL ovf_latency: %0d edges, want 33", edges);
    end
    vectors++;
    if ({quotient, remainder, div_zero} !== {OVF_Q, OVF_R, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_min_neg1: q=%h r=%h dz=%b, want q=%h r=%h dz=0",
               quotient, remainder, div_zero, OVF_Q, OVF_R);
    end
  endtask

  task automatic test_div_zero();
    int edges;
    launch(32'd5, 32'd0);
    vectors++;
    if ({result_rdy, div_zero, busy, quotient, remainder} !== {1'b1, 1'b1, 1'b0, 32'd0, 32'd5}) begin
      miscompares++;
      $display("FAIL dz_5_0: rdy=%b dz=%b busy=%b q=%0d r=%0d, want rdy=1 dz=1 busy=0 q=0 r=5",
               result_rdy, div_zero, busy, quotient, remainder);
    end
    step();
    vectors++;
    if ({result_rdy, div_zero} !== 2'b01) begin
      miscompares++;
      $display("FAIL dz_pulse: rdy=%b dz=%b, want rdy=0 dz=1", result_rdy, div_zero);
    end
    launch(32'd9, 32'd3);
    wait_rdy(edges);
    vectors++;
    if ({edges == 33, quotient, remainder, div_zero} !== {1'b1, 32'd3, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL dz_then_9_3: edges=%0d q=%0d r=%0d dz=%b, want edges=33 q=3 r=0 dz=0",
               edges, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    launch(32'd100, 32'd7);
    repeat (4) step();
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    step();                         // edge 5
    start    = 1'b0;
    wait_rdy(edges);
    vectors++;
    if (edges !== 28) begin
      miscompares++;
      $display("FAIL ignore_latency: %0d edges after edge 5, want 28", edges);
    end
    vectors++;
    if ({quotient, remainder, div_zero} !== {32'd14, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_start: q=%0d r=%0d dz=%b, want q=14 r=2 dz=0",
               quotient, remainder, div_zero);
    end
  endtask

  task automatic test_reset_mid();
    int rdy_seen;
    launch(32'd100, 32'd7);
    repeat (9) step();
    #2 reset = 1'b1;                // between edges 9 and 10
    #1;
    vectors++;
    if ({quotient, remainder, div_zero, busy, result_rdy} !== {(2*W+3){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_mid: q=%h r=%h dz=%b busy=%b rdy=%b, want all zero",
               quotient, remainder, div_zero, busy, result_rdy);
    end
    #1 reset = 1'b0;
    rdy_seen = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (result_rdy || busy) rdy_seen++;
    end
    vectors++;
    if (rdy_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: %0d cycles with busy/rdy after reset, want 0", rdy_seen);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    launch(32'd100, 32'd7);
    wait_rdy(edges);
    vectors++;
    if ({edges == 33, quotient, remainder} !== {1'b1, 32'd14, 32'd2}) begin
      miscompares++;
      $display("FAIL b2b_first: edges=%0d q=%0d r=%0d, want edges=33 q=14 r=2",
               edges, quotient, remainder);
    end
    launch(32'd20, 32'd6);          // start on the result_rdy cycle
    vectors++;
    if ({busy, result_rdy, quotient} !== {1'b1, 1'b0, 32'd14}) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b rdy=%b q=%0d, want busy=1 rdy=0 q=14",
               busy, result_rdy, quotient);
    end
    wait_rdy(edges);
    vectors++;
    if ({edges == 33, quotient, remainder, div_zero} !== {1'b1, 32'd3, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_20_6: edges=%0d q=%0d r=%0d dz=%b, want edges=33 q=3 r=2 dz=0",
               edges, quotient, remainder, div_zero);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_handling();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
